// File: rtl/mem_controller_loadless_pkg.sv
// Shared types and defaults for the store-only memory controller.
package mem_controller_loadless_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    END  = 2'd2
  } mc_state_t;

  localparam int DEFAULT_CNT_W = 32;

endpackage

// File: rtl/mem_controller_loadless_checker.sv
// Invariant checks on the pending-store counter.
module mem_controller_loadless_checker #(
  parameter int CNT_W = 32
) (
  input logic             clk,
  input logic             rst,
  input logic [CNT_W-1:0] pending,
  input logic [CNT_W-1:0] ctrl_sum,
  input logic             grant_any
);

  logic [CNT_W:0] wide_sum;

  assign wide_sum = {1'b0, pending} + {1'b0, ctrl_sum};

  // Announced stores must never push the counter past its range.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !wide_sum[CNT_W]);

  // A store is only issued against an outstanding announcement.
  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(grant_any && (pending == '0)));

endmodule

// File: rtl/mem_controller_loadless_write_memory_arbiter.sv
// Fixed-priority store arbiter: lowest eligible port wins, addr/data taken as a
// pair, and the winning pair is registered onto the BRAM write port.
module write_memory_arbiter #(
  parameter int NUM_STORES = 1,
  parameter int DATA_TYPE  = 32,
  parameter int ADDR_TYPE  = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            enable,
  input  logic [NUM_STORES*ADDR_TYPE-1:0] st_addr,
  input  logic [NUM_STORES-1:0]           st_addr_valid,
  input  logic [NUM_STORES*DATA_TYPE-1:0] st_data,
  input  logic [NUM_STORES-1:0]           st_data_valid,
  output logic [NUM_STORES-1:0]           grant,
  output logic                            grant_any,
  output logic                            store_en,
  output logic [ADDR_TYPE-1:0]            store_addr,
  output logic [DATA_TYPE-1:0]            store_data
);

  logic [ADDR_TYPE-1:0] sel_addr;
  logic [DATA_TYPE-1:0] sel_data;
  logic                 found;

  // Lowest-index port with both address and data valid is granted.
  always_comb begin
    grant    = '0;
    found    = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_STORES; i++) begin
      if (enable && !found && st_addr_valid[i] && st_data_valid[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
        sel_addr = st_addr[i*ADDR_TYPE +: ADDR_TYPE];
        sel_data = st_data[i*DATA_TYPE +: DATA_TYPE];
      end else begin
        grant[i] = 1'b0;
      end
    end
  end

  assign grant_any = found;

  // Write port register: address/data hold when no store is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      store_en   <= 1'b0;
      store_addr <= '0;
      store_data <= '0;
    end else if (grant_any) begin
      store_en   <= 1'b1;
      store_addr <= sel_addr;
      store_data <= sel_data;
    end else begin
      store_en   <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_controller_loadless.sv
// Store-only memory controller: counts announced stores, arbitrates store ports
// onto one BRAM write port and signals memEnd once everything has landed.
module mem_controller_loadless
  import mem_controller_loadless_pkg::*;
#(
  parameter int NUM_CONTROLS = 1,
  parameter int NUM_STORES   = 1,
  parameter int DATA_TYPE    = 32,
  parameter int ADDR_TYPE    = 32,
  parameter int CNT_W        = DEFAULT_CNT_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            memStart_valid,
  output logic                            memStart_ready,
  output logic                            memEnd_valid,
  input  logic                            memEnd_ready,
  input  logic                            ctrlEnd_valid,
  output logic                            ctrlEnd_ready,
  input  logic [NUM_CONTROLS*CNT_W-1:0]   ctrl,
  input  logic [NUM_CONTROLS-1:0]         ctrl_valid,
  output logic [NUM_CONTROLS-1:0]         ctrl_ready,
  input  logic [NUM_STORES*ADDR_TYPE-1:0] stAddr,
  input  logic [NUM_STORES-1:0]           stAddr_valid,
  output logic [NUM_STORES-1:0]           stAddr_ready,
  input  logic [NUM_STORES*DATA_TYPE-1:0] stData,
  input  logic [NUM_STORES-1:0]           stData_valid,
  output logic [NUM_STORES-1:0]           stData_ready,
  input  logic [DATA_TYPE-1:0]            loadData,
  output logic                            loadEn,
  output logic [ADDR_TYPE-1:0]            loadAddr,
  output logic                            storeEn,
  output logic [ADDR_TYPE-1:0]            storeAddr,
  output logic [DATA_TYPE-1:0]            storeData
);

  mc_state_t        state, state_next;
  logic [CNT_W-1:0] pending, pending_next, ctrl_sum, grant_dec;
  logic             end_seen, end_seen_next;
  logic             start_ready_c, end_ready_c, end_valid_c, in_run;
  logic             issue_enable, grant_any;
  logic [NUM_STORES-1:0] grant;
  logic             unused_load;

  assign unused_load = ^loadData;
  assign loadEn      = 1'b0;
  assign loadAddr    = '0;

  // Every ready/valid output is forced low while reset is asserted.
  assign memStart_ready = start_ready_c & ~rst;
  assign ctrlEnd_ready  = end_ready_c & ~rst;
  assign memEnd_valid   = end_valid_c & ~rst;
  assign ctrl_ready     = {NUM_CONTROLS{in_run & ~rst}};
  assign stAddr_ready   = grant;
  assign stData_ready   = grant;

  assign issue_enable = in_run && (pending != '0) && !rst;
  assign grant_dec    = {{(CNT_W-1){1'b0}}, grant_any};

  // Sum of store counts accepted this cycle across all control channels.
  always_comb begin
    ctrl_sum = '0;
    for (int i = 0; i < NUM_CONTROLS; i++) begin
      if (ctrl_valid[i] && ctrl_ready[i]) begin
        ctrl_sum = ctrl_sum + ctrl[i*CNT_W +: CNT_W];
      end else begin
        ctrl_sum = ctrl_sum;
      end
    end
  end

  assign pending_next = pending + ctrl_sum - grant_dec;

  // Next-state and handshake decode of the controller FSM.
  always_comb begin
    state_next    = state;
    end_seen_next = end_seen;
    start_ready_c = 1'b0;
    end_ready_c   = 1'b0;
    end_valid_c   = 1'b0;
    in_run        = 1'b0;
    case (state)
      IDLE: begin
        start_ready_c = 1'b1;
        if (memStart_valid) begin
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        in_run      = 1'b1;
        end_ready_c = !end_seen;
        if (ctrlEnd_valid && !end_seen) begin
          end_seen_next = 1'b1;
        end else begin
          end_seen_next = end_seen;
        end
        // storeEn low means the final write has already reached the BRAM
        if (end_seen && (pending == '0) && (ctrl_valid == '0) && !storeEn) begin
          state_next = END;
        end else begin
          state_next = RUN;
        end
      end
      END: begin
        end_valid_c = 1'b1;
        if (memEnd_ready) begin
          state_next    = IDLE;
          end_seen_next = 1'b0;
        end else begin
          state_next = END;
        end
      end
      default: begin
        state_next    = IDLE;
        end_seen_next = 1'b0;
      end
    endcase
  end

  // FSM, pending-store counter and end-of-control flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pending  <= '0;
      end_seen <= 1'b0;
    end else begin
      state    <= state_next;
      pending  <= pending_next;
      end_seen <= end_seen_next;
    end
  end

  write_memory_arbiter #(
    .NUM_STORES (NUM_STORES),
    .DATA_TYPE  (DATA_TYPE),
    .ADDR_TYPE  (ADDR_TYPE)
  ) u_arb (
    .clk           (clk),
    .rst           (rst),
    .enable        (issue_enable),
    .st_addr       (stAddr),
    .st_addr_valid (stAddr_valid),
    .st_data       (stData),
    .st_data_valid (stData_valid),
    .grant         (grant),
    .grant_any     (grant_any),
    .store_en      (storeEn),
    .store_addr    (storeAddr),
    .store_data    (storeData)
  );

  mem_controller_loadless_checker #(
    .CNT_W (CNT_W)
  ) u_chk (
    .clk       (clk),
    .rst       (rst),
    .pending   (pending),
    .ctrl_sum  (ctrl_sum),
    .grant_any (grant_any)
  );

endmodule

// File: tb/tb_mem_controller_loadless.sv
// Directed bench for the store-only memory controller (3 store ports).
module tb_mem_controller_loadless;

  localparam int NC = 1;
  localparam int NS = 3;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int CW = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             memStart_valid, memStart_ready;
  logic             memEnd_valid, memEnd_ready;
  logic             ctrlEnd_valid, ctrlEnd_ready;
  logic [NC*CW-1:0] ctrl;
  logic [NC-1:0]    ctrl_valid, ctrl_ready;
  logic [NS*AW-1:0] stAddr;
  logic [NS-1:0]    stAddr_valid, stAddr_ready;
  logic [NS*DW-1:0] stData;
  logic [NS-1:0]    stData_valid, stData_ready;
  logic [DW-1:0]    loadData;
  logic             loadEn;
  logic [AW-1:0]    loadAddr;
  logic             storeEn;
  logic [AW-1:0]    storeAddr;
  logic [DW-1:0]    storeData;

  int n_vec = 0;
  int n_bad = 0;

  mem_controller_loadless #(
    .NUM_CONTROLS (NC),
    .NUM_STORES   (NS),
    .DATA_TYPE    (DW),
    .ADDR_TYPE    (AW),
    .CNT_W        (CW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .memStart_valid (memStart_valid),
    .memStart_ready (memStart_ready),
    .memEnd_valid   (memEnd_valid),
    .memEnd_ready   (memEnd_ready),
    .ctrlEnd_valid  (ctrlEnd_valid),
    .ctrlEnd_ready  (ctrlEnd_ready),
    .ctrl           (ctrl),
    .ctrl_valid     (ctrl_valid),
    .ctrl_ready     (ctrl_ready),
    .stAddr         (stAddr),
    .stAddr_valid   (stAddr_valid),
    .stAddr_ready   (stAddr_ready),
    .stData         (stData),
    .stData_valid   (stData_valid),
    .stData_ready   (stData_ready),
    .loadData       (loadData),
    .loadEn         (loadEn),
    .loadAddr       (loadAddr),
    .storeEn        (storeEn),
    .storeAddr      (storeAddr),
    .storeData      (storeData)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then wait off the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_port(input int p, input logic [31:0] a, input logic [31:0] d,
                          input logic av, input logic dv);
    stAddr[p*AW +: AW] = a;
    stData[p*DW +: DW] = d;
    stAddr_valid[p]    = av;
    stData_valid[p]    = dv;
  endtask

  task automatic send_ctrl(input logic [31:0] n);
    ctrl       = n;
    ctrl_valid = 1'b1;
    tick();
    ctrl_valid = 1'b0;
  endtask

  task automatic start_run();
    memStart_valid = 1'b1;
    tick();
    memStart_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    memStart_valid = 1'b0; memEnd_ready = 1'b0; ctrlEnd_valid = 1'b0;
    ctrl = '0; ctrl_valid = '0;
    stAddr = '0; stAddr_valid = '0; stData = '0; stData_valid = '0;
    loadData = 32'hDEAD_BEEF;

    // Reset
    repeat (3) tick();
    check("rst_storeEn", storeEn, 1'b0);
    check("rst_memEnd", memEnd_valid, 1'b0);
    check("rst_startrdy", memStart_ready, 1'b0);
    check("rst_addr", storeAddr, 32'h0);
    rst = 1'b0;
    settle();
    check("idle_startrdy", memStart_ready, 1'b1);
    check("loadEn", loadEn, 1'b0);
    check("loadAddr", loadAddr, 32'h0);

    // Two stores on port 0, then ctrlEnd
    start_run();
    check("run_ctrlrdy", ctrl_ready, 1'b1);
    check("run_startrdy", memStart_ready, 1'b0);
    send_ctrl(32'd2);
    set_port(0, 32'h10, 32'hAA, 1'b1, 1'b1);
    settle();
    check("s1_rdy", stAddr_ready, 3'b001);
    tick();
    check("s1_en", storeEn, 1'b1);
    check("s1_addr", storeAddr, 32'h10);
    check("s1_data", storeData, 32'hAA);
    set_port(0, 32'h14, 32'hBB, 1'b1, 1'b1);
    tick();
    check("s2_en", storeEn, 1'b1);
    check("s2_addr", storeAddr, 32'h14);
    check("s2_data", storeData, 32'hBB);
    set_port(0, 32'h0, 32'h0, 1'b0, 1'b0);
    ctrlEnd_valid = 1'b1;
    settle();
    check("ce_rdy", ctrlEnd_ready, 1'b1);
    tick();
    ctrlEnd_valid = 1'b0;
    check("s2_en_off", storeEn, 1'b0);
    check("s2_addr_hold", storeAddr, 32'h14);
    check("end_plus1", memEnd_valid, 1'b0);
    check("ce_rdy_off", ctrlEnd_ready, 1'b0);
    tick();
    check("end_plus2", memEnd_valid, 1'b1);
    memEnd_ready = 1'b1;
    tick();
    memEnd_ready = 1'b0;
    check("back_idle", memStart_ready, 1'b1);
    check("end_drop", memEnd_valid, 1'b0);

    // Ports 1 and 2 together: port 1 first
    start_run();
    send_ctrl(32'd2);
    set_port(1, 32'h100, 32'h11, 1'b1, 1'b1);
    set_port(2, 32'h200, 32'h22, 1'b1, 1'b1);
    settle();
    check("pri_ardy", stAddr_ready, 3'b010);
    check("pri_drdy", stData_ready, 3'b010);
    tick();
    check("pri_w1", storeAddr, 32'h100);
    check("pri_d1", storeData, 32'h11);
    set_port(1, 32'h0, 32'h0, 1'b0, 1'b0);
    settle();
    check("pri_ardy2", stAddr_ready, 3'b100);
    tick();
    check("pri_w2", storeAddr, 32'h200);
    check("pri_d2", storeData, 32'h22);
    check("pri_en2", storeEn, 1'b1);
    settle();
    check("pri_nordy", stAddr_ready, 3'b000);
    set_port(2, 32'h0, 32'h0, 1'b0, 1'b0);

    // Store stalled with pending=0
    set_port(0, 32'h20, 32'hCC, 1'b1, 1'b1);
    settle();
    check("stall_rdy", stAddr_ready, 3'b000);
    tick();
    check("stall_en", storeEn, 1'b0);
    check("stall_rdy2", stData_ready, 3'b000);
    ctrl = 32'd1; ctrl_valid = 1'b1;
    settle();
    check("stall_rdy3", stAddr_ready, 3'b000);
    tick();
    ctrl_valid = 1'b0;
    check("stall_en2", storeEn, 1'b0);
    settle();
    check("stall_grant", stAddr_ready, 3'b001);
    tick();
    check("stall_wen", storeEn, 1'b1);
    check("stall_wa", storeAddr, 32'h20);
    set_port(0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Address without data: no split acceptance
    send_ctrl(32'd1);
    set_port(0, 32'h30, 32'hDD, 1'b1, 1'b0);
    settle();
    check("split_ardy", stAddr_ready, 3'b000);
    check("split_drdy", stData_ready, 3'b000);
    tick();
    check("split_en", storeEn, 1'b0);
    stData_valid[0] = 1'b1;
    settle();
    check("pair_rdy", stAddr_ready, 3'b001);
    tick();
    check("pair_a", storeAddr, 32'h30);
    check("pair_d", storeData, 32'hDD);
    set_port(0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    check("pair_single", storeEn, 1'b0);

    // ctrlEnd before the last store, memEnd held under backpressure
    send_ctrl(32'd1);
    ctrlEnd_valid = 1'b1;
    tick();
    ctrlEnd_valid = 1'b0;
    tick();
    check("late_end0", memEnd_valid, 1'b0);
    set_port(0, 32'h40, 32'hEE, 1'b1, 1'b1);
    tick();
    set_port(0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("late_wen", storeEn, 1'b1);
    check("late_wa", storeAddr, 32'h40);
    check("late_end1", memEnd_valid, 1'b0);
    tick();
    check("late_end2", memEnd_valid, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("end_hold", memEnd_valid, 1'b1);
    end
    memEnd_ready = 1'b1;
    tick();
    memEnd_ready = 1'b0;
    check("final_idle", memStart_ready, 1'b1);
    check("final_end", memEnd_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
